// File: rtl/debug_run_controller_pkg.sv
// Shared command codes, FSM states and word-source selects for the debug run controller.
package debug_run_controller_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_REGS = 8'h72;
    localparam logic [7:0] CMD_MEM  = 8'h6D;
    localparam logic [7:0] CMD_PC   = 8'h70;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_RD_WAIT,
        S_LOAD,
        S_TX,
        S_NEXT
    } state_t;

    typedef enum logic [1:0] {
        SRC_REG,
        SRC_MEM,
        SRC_PC
    } src_t;

endpackage

// File: rtl/debug_run_controller_if.sv
// UART byte handshake plus core step/debug-read signals; master = controller, slave = UART/core side.
interface debug_run_controller_if #(
    parameter int NB = 32
) ();
    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          o_rx_ready;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          o_step;
    logic          i_mips_halt;
    logic [NB-1:0] i_mips_pc;
    logic [4:0]    o_debug_reg_num;
    logic [NB-1:0] i_debug_reg_data;
    logic [NB-1:0] o_debug_address;
    logic [NB-1:0] i_debug_mem_data;
    logic          o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_mips_halt, i_mips_pc,
               i_debug_reg_data, i_debug_mem_data,
        output o_rx_ready, o_tx_data, o_tx_valid, o_step, o_debug_reg_num,
               o_debug_address, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_mips_halt, i_mips_pc,
               i_debug_reg_data, i_debug_mem_data,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_step, o_debug_reg_num,
               o_debug_address, o_busy
    );
endinterface

// File: rtl/debug_word_serializer.sv
// Loads one word and emits it MSB byte first on a valid/ready port; byte held while tx_ready_i is low.
// done_o pulses in the cycle the last byte of the word is accepted.
module debug_word_serializer #(
    parameter int NB = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [NB-1:0] word_i,
    input  logic          tx_ready_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    output logic          done_o
);
    localparam int NBYTES = NB / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [NB-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          accept, last;

    assign accept = vld_q && tx_ready_i;
    assign last   = (cnt_q == CW'(NBYTES - 1));
    assign done_o = accept && last;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
            vld_d   = 1'b1;
        end else if (accept) begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + CW'(1);
            vld_d   = !last;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    assign tx_data_o  = shift_q[NB-1 -: 8];
    assign tx_valid_o = vld_q;
endmodule

// File: rtl/debug_run_controller.sv
// Host debug sequencer for the pipeline core: run/step control and reg/mem/PC dumps streamed as bytes.
// DEBUG_CYCLE_COUNT_EN adds a step-cycle counter appended to the 'p' response.
module debug_run_controller
    import debug_run_controller_pkg::*;
#(
    parameter int NB              = 32,
    parameter int N_REGS          = 32,
    parameter int TAM_DATA_MEMORY = 16
) (
    input logic                    i_clk,
    input logic                    i_reset,
    debug_run_controller_if.master dbg
);
    localparam int MAX_WORDS = (N_REGS > TAM_DATA_MEMORY) ? N_REGS : TAM_DATA_MEMORY;
    localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int PC_WORDS  = 2;
`else
    localparam int PC_WORDS  = 1;
`endif

    state_t         state_q;
    src_t           src_q;
    logic [IDX_W-1:0] idx_q, idx_inc, last_idx;
    logic           halted_q;
    logic [4:0]     reg_num_q;
    logic [NB-1:0]  addr_q;
    logic [NB-1:0]  load_word;
    logic           step, ser_done;
    logic [7:0]     tx_data;
    logic           tx_valid;

    assign idx_inc = idx_q + IDX_W'(1);
    // The core advances only on cycles this is high; halt drops it in the same cycle.
    assign step = (state_q == S_STEP) || ((state_q == S_RUN) && !dbg.i_mips_halt);

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [NB-1:0] cyc_q;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   cyc_q <= '0;
        else if (step) cyc_q <= cyc_q + NB'(1);
    end
`endif

    always_comb begin
        last_idx = IDX_W'(PC_WORDS - 1);
        case (src_q)
            SRC_REG: last_idx = IDX_W'(N_REGS - 1);
            SRC_MEM: last_idx = IDX_W'(TAM_DATA_MEMORY - 1);
            default: ;
        endcase
    end

    always_comb begin
        load_word = dbg.i_mips_pc;
        case (src_q)
            SRC_REG: load_word = dbg.i_debug_reg_data;
            SRC_MEM: load_word = dbg.i_debug_mem_data;
            default: begin
`ifdef DEBUG_CYCLE_COUNT_EN
                if (idx_q != '0) load_word = cyc_q;
`endif
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            src_q     <= SRC_REG;
            idx_q     <= '0;
            halted_q  <= 1'b0;
            reg_num_q <= '0;
            addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (dbg.i_rx_valid) begin
                    idx_q <= '0;
                    case (dbg.i_rx_data)
                        CMD_RUN:  if (!halted_q) state_q <= S_RUN;
                        CMD_STEP: if (!halted_q) state_q <= S_STEP;
                        CMD_REGS: begin
                            src_q     <= SRC_REG;
                            reg_num_q <= '0;
                            state_q   <= S_RD_WAIT;
                        end
                        CMD_MEM: begin
                            src_q   <= SRC_MEM;
                            addr_q  <= '0;
                            state_q <= S_RD_WAIT;
                        end
                        CMD_PC: begin
                            src_q   <= SRC_PC;
                            state_q <= S_LOAD;
                        end
                        default: ;
                    endcase
                end
                S_RUN: if (dbg.i_mips_halt) begin
                    halted_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                S_STEP: begin
                    if (dbg.i_mips_halt) halted_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_RD_WAIT: state_q <= S_LOAD;
                S_LOAD:    state_q <= S_TX;
                S_TX:      if (ser_done) state_q <= S_NEXT;
                S_NEXT: begin
                    if (idx_q == last_idx) begin
                        state_q <= S_IDLE;
                    end else begin
                        idx_q <= idx_inc;
                        if (src_q == SRC_REG) reg_num_q <= idx_inc[4:0];
                        if (src_q == SRC_MEM) addr_q <= NB'({idx_inc, 2'b00});
                        // PC/cycle words come straight from registers, no read latency to cover.
                        state_q <= (src_q == SRC_PC) ? S_LOAD : S_RD_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    debug_word_serializer #(.NB(NB)) u_ser (
        .clk_i      (i_clk),
        .rst_i      (i_reset),
        .load_i     (state_q == S_LOAD),
        .word_i     (load_word),
        .tx_ready_i (dbg.i_tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .done_o     (ser_done)
    );

    assign dbg.o_tx_data       = tx_data;
    assign dbg.o_tx_valid      = tx_valid;
    assign dbg.o_step          = step;
    assign dbg.o_rx_ready      = (state_q == S_IDLE);
    assign dbg.o_busy          = (state_q != S_IDLE);
    assign dbg.o_debug_reg_num = reg_num_q;
    assign dbg.o_debug_address = addr_q;
endmodule
